// File: rtl/ss_pattern_capture_if.sv
// Seven-segment readback bus: the multiplexed display inputs (anodes and
// cathodes) together with the decoded digit results.
interface ss_pattern_capture_if #(
  parameter int DIGITS = 4
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]   an;
  logic [6:0]          a_to_g;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_done;
  logic                err_strobe;
  logic [IDX_W-1:0]    err_index;

  // Display side: drives the bus and observes the readback.
  modport master (
    output an, a_to_g,
    input  digits, digit_valid, frame_done, err_strobe, err_index
  );

  // Capture side: observes the bus and produces the readback.
  modport slave (
    input  an, a_to_g,
    output digits, digit_valid, frame_done, err_strobe, err_index
  );
endinterface

// File: rtl/ss_pattern_capture.sv
// Seven-segment pattern capture: watches a multiplexed, active-low display
// bus, waits for each anode/segment pair to settle, and turns the segment
// pattern back into a BCD digit. Invalid patterns and multi-anode overlaps
// raise a one-cycle error strobe; a frame strobe marks a full refresh.
module ss_pattern_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ss_pattern_capture_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int RAW_W = DIGITS + 7;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  // Decoded pattern fields: {valid digit, blank, value}.
  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [3:0] value;
  } seg_dec_t;

  // Map an active-low a..g pattern (bit 6 = a) onto its digit value.
  function automatic seg_dec_t decode_seg(input logic [6:0] seg);
    seg_dec_t d;
    d = '{is_digit: 1'b1, is_blank: 1'b0, value: 4'hF};
    case (seg)
      7'b0000001: d.value = 4'd0;
      7'b1001111: d.value = 4'd1;
      7'b0010010: d.value = 4'd2;
      7'b0000110: d.value = 4'd3;
      7'b1001100: d.value = 4'd4;
      7'b0100100: d.value = 4'd5;
      7'b0100000: d.value = 4'd6;
      7'b0001111: d.value = 4'd7;
      7'b0000000: d.value = 4'd8;
      7'b0000100: d.value = 4'd9;
      7'b1111111: begin
        d.is_digit = 1'b0;
        d.is_blank = 1'b1;
      end
      default: d.is_digit = 1'b0;
    endcase
    return d;
  endfunction

  // Registered state
  logic [RAW_W-1:0]    r_q;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [4*DIGITS-1:0] digits_q,     digits_d;
  logic [DIGITS-1:0]   valid_q,      valid_d;
  logic [DIGITS-1:0]   seen_q,       seen_d;
  logic                frame_done_q, frame_done_d;
  logic                err_strobe_q, err_strobe_d;
  logic [IDX_W-1:0]    err_index_q,  err_index_d;

  // Combinational helpers
  logic [RAW_W-1:0] raw;
  logic             stable;
  logic             sample;
  logic [3:0]       low_cnt;
  logic [IDX_W-1:0] sel_idx;
  logic [DIGITS-1:0] cap_mask;
  seg_dec_t         dec;

  assign raw    = {bus.an, bus.a_to_g};
  assign stable = (raw == r_q);
  // The edge that moves cnt from STABLE_CYCLES-1 to STABLE_CYCLES; a
  // saturated counter stays at CNT_MAX and cannot re-arm this.
  assign sample = stable && (cnt_q == CNT_ARM);
  assign dec    = decode_seg(bus.a_to_g);

  // Count the low anodes and remember which one is low.
  always_comb begin
    low_cnt = 4'd0;
    sel_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bus.an[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Next-state for stability counter, captured slots, errors and frame mask.
  always_comb begin
    cnt_d        = cnt_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    err_strobe_d = 1'b0;
    err_index_d  = err_index_q;
    cap_mask     = '0;

    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (sample) begin
      if (low_cnt >= 4'd2) begin
        // Overlapping anodes: the pattern belongs to no single slot.
        err_strobe_d = 1'b1;
      end else if (low_cnt == 4'd1) begin
        if (dec.is_digit) begin
          digits_d[{sel_idx, 2'b00} +: 4] = dec.value;
          valid_d[sel_idx]                = 1'b1;
          cap_mask[sel_idx]               = 1'b1;
        end else if (dec.is_blank) begin
          digits_d[{sel_idx, 2'b00} +: 4] = 4'hF;
          valid_d[sel_idx]                = 1'b0;
          cap_mask[sel_idx]               = 1'b1;
        end else begin
          err_strobe_d = 1'b1;
          err_index_d  = sel_idx;
        end
      end
    end

    // A full mask fires the frame strobe and clears; a capture landing on
    // that same edge is kept in the fresh mask.
    frame_done_d = &seen_q;
    seen_d       = ((&seen_q) ? '0 : seen_q) | cap_mask;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q          <= '1;
      cnt_q        <= '0;
      digits_q     <= '1;
      valid_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      err_strobe_q <= 1'b0;
      err_index_q  <= '0;
    end else begin
      r_q          <= raw;
      cnt_q        <= cnt_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      err_strobe_q <= err_strobe_d;
      err_index_q  <= err_index_d;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_strobe  = err_strobe_q;
  assign bus.err_index   = err_index_q;

endmodule

// File: doc/ss_pattern_capture.md
# ss_pattern_capture

Reads a multiplexed, active-low seven-segment display bus (anode enables plus `a_to_g` cathodes, the output format of the clock's 0-9 segment decoder) and converts it back into BCD digits. It runs on the system clock and sits beside the display driver as a self-check and readback path. A digit is captured only after its anode/segment pair has held stable for a programmable number of cycles. Invalid patterns and multi-anode conditions are flagged, and a frame strobe fires once every digit position has been refreshed.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions; range 1-8.
- `STABLE_CYCLES`, default 4: consecutive stable edges required before capture; must be ≥1.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `an` in DIGITS: anode enables, active-low; bit i selects digit i.
- `a_to_g` in 7: segment cathodes, active-low (0 = lit); bit 6 = a … bit 0 = g.
- `digits` out 4*DIGITS: captured BCD; digit i occupies bits [4i+3:4i]; 4'hF = blank.
- `digit_valid` out DIGITS: bit i is 1 when slot i holds a decoded 0-9.
- `frame_done` out 1: one-cycle pulse when all DIGITS slots have been captured since the last pulse.
- `err_strobe` out 1: one-cycle pulse on an invalid pattern or when more than one anode is low.
- `err_index` out clog2(DIGITS) (min 1): digit index of the last invalid-pattern error.

## Operation
- Pattern decode (bit6..bit0 → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - 1111111→blank
  - Every other pattern is invalid.
- Stability tracker:
  - `r` holds the previous {an,a_to_g}; `cnt` width is clog2(STABLE_CYCLES+1).
  - Each edge: if the raw input ≠ `r`, then `cnt`←0; else if `cnt`≠STABLE_CYCLES, then `cnt`←`cnt`+1. `r`←raw every edge.
  - A sample event occurs on the edge where `cnt` goes from STABLE_CYCLES-1 to STABLE_CYCLES. It fires exactly once per stable window; a saturated `cnt` never re-fires.
- On a sample event:
  - `an` all ones: no action.
  - `an` with ≥2 bits low: `err_strobe` pulses; no capture; `err_index` unchanged.
  - `an` with exactly bit i low:
    - Valid 0-9: slot i←value, `digit_valid[i]`←1, `seen[i]`←1.
    - Blank: slot i←4'hF, `digit_valid[i]`←0, `seen[i]`←1.
    - Invalid: slot i unchanged, `err_strobe` pulses, `err_index`←i, `seen[i]` unchanged.
- Frame tracking:
  - Internal mask `seen[DIGITS-1:0]`.
  - On the edge after `seen` becomes all ones, `frame_done` pulses and `seen` clears.
  - A capture on that same clearing edge sets its bit in the freshly cleared mask; the capture is not lost.
- Reset values: `digits` all 4'hF, `digit_valid` 0, `frame_done` 0, `err_strobe` 0, `err_index` 0, `r` all ones, `cnt` 0, `seen` 0.

## Timing
- Let E0 be the first rising edge at which a new {an,a_to_g} value is present. The capture registers update on edge E(STABLE_CYCLES). The input must therefore be held for STABLE_CYCLES+1 edges (5 edges with the default).
- `err_strobe` and `err_index` update on the sample-event edge. `err_strobe` is high for exactly one cycle.
- `frame_done` rises one edge after the capture that completes `seen`, and stays high for exactly one cycle.
- Any input change before E(STABLE_CYCLES) restarts the window: no capture and no error.
- Asserting `rst_n` low forces all reset values immediately, without waiting for a clock edge. After release, a full stable window is required before any capture.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset, then `an`=1110 and `a_to_g`=0000110 held for 5 edges → after E4, `digits[3:0]`=3 and `digit_valid`=0001. Both are unchanged after E3.
- Same stimulus held for only 4 edges, then `an`=1111 → `digits` stays 16'hFFFF and `digit_valid` stays 0.
- Scan `an`=1110/1101/1011/0111 with 1001111/0010010/0100100/0000100, 5 edges each → `digits`=16'h9521, `digit_valid`=1111, and `frame_done` pulses once, one edge after the fourth capture.
- `an`=1011 with `a_to_g`=1111110 held for 5 edges → `err_strobe` pulses for 1 cycle, `err_index`=2, slot 2 unchanged, no `frame_done`.
- `an`=1100 held for 5 edges → `err_strobe` pulses, no slot changes. `a_to_g`=1111111 on digit 0 → slot 0 = F and `digit_valid[0]`=0.
- Drive `rst_n` low mid-window after 3 stable edges, then release → outputs return to reset values immediately, and capture occurs only after a fresh 5-edge window.
